// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//   Stall/flush sequencer for the 5-stage int+FP pipeline. Produces the write
//   enables of the PC, IF/ID and ID/EX registers together with the bubble and
//   flush controls. It detects integer and FP load-use hazards and taken-branch
//   flushes, and holds a multi-cycle FP multiply/divide in EX for its full
//   latency while feeding NOPs into EX/MEM.
//
//   Optional feature: define HAZARD_PERF_EN to build the saturating 32-bit
//   stall-cycle counter. Without it stallCycles is tied to zero.
//
// Parameters
//   FP_MUL_LAT  cycles an FP multiply occupies EX (>= 2)
//   FP_DIV_LAT  cycles an FP divide occupies EX (>= 2)
//   CNT_W       latency counter width, holds max(LAT)-2
//
// Ports
//   clk, rst_n              clock; synchronous active-low reset
//   idRs/idRt, idUsesRs/Rt  integer sources of the ID instruction and use flags
//   idFpRs/idFpRt, idFpUses FP sources of the ID instruction and use flag
//   exRw                    destination register of the EX instruction
//   exMemRead/exFpLoad      EX instruction is an integer / FP load
//   exFpMul/exFpDiv         EX instruction is an FP multiply / divide
//   branchTaken             EX resolved a taken branch or jump
//   pcWrite, ifIdWrite, idExWrite   register write enables
//   ifIdFlush               IF/ID loads a NOP
//   idExBubble, exMemBubble control fields forced to zero
//   fpBusy                  multi-cycle FP op held in EX
//   stallCycles             count of cycles with pcWrite low
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int FP_MUL_LAT = 4,
    parameter int FP_DIV_LAT = 16,
    parameter int CNT_W      = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  idRs,
    input  logic [4:0]  idRt,
    input  logic        idUsesRs,
    input  logic        idUsesRt,
    input  logic [4:0]  idFpRs,
    input  logic [4:0]  idFpRt,
    input  logic        idFpUses,
    input  logic [4:0]  exRw,
    input  logic        exMemRead,
    input  logic        exFpLoad,
    input  logic        exFpMul,
    input  logic        exFpDiv,
    input  logic        branchTaken,
    output logic        pcWrite,
    output logic        ifIdWrite,
    output logic        ifIdFlush,
    output logic        idExWrite,
    output logic        idExBubble,
    output logic        exMemBubble,
    output logic        fpBusy,
    output logic [31:0] stallCycles
);

    typedef enum logic [0:0] {RUN, FP_BUSY} state_e;

    // The detect cycle and the release cycle are not counted by cnt, hence -2.
    localparam logic [CNT_W-1:0] MUL_INIT = CNT_W'(FP_MUL_LAT - 2);
    localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(FP_DIV_LAT - 2);

    state_e           st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             int_hit, fp_hit;

    // Integer r0 is hard-wired so a load to it never creates a dependence;
    // the FP file has no such register.
    assign int_hit = exMemRead && (exRw != 5'd0) &&
                     ((idUsesRs && (idRs == exRw)) || (idUsesRt && (idRt == exRw)));
    assign fp_hit  = exFpLoad && idFpUses && ((idFpRs == exRw) || (idFpRt == exRw));

    always_comb begin
        // NOTE: every output and next-state gets a default first, so no path
        // through the decision tree can leave one unassigned and infer a latch.
        st_d        = st_q;
        cnt_d       = cnt_q;
        pcWrite     = 1'b1;
        ifIdWrite   = 1'b1;
        idExWrite   = 1'b1;
        ifIdFlush   = 1'b0;
        idExBubble  = 1'b0;
        exMemBubble = 1'b0;
        fpBusy      = 1'b0;

        if (!rst_n) begin
            // Keep the registers loading so the pipeline fills with NOPs.
            ifIdFlush   = 1'b1;
            idExBubble  = 1'b1;
            exMemBubble = 1'b1;
            st_d        = RUN;
            cnt_d       = '0;
        end else begin
            unique case (st_q)
                RUN: begin
                    if (branchTaken) begin
                        ifIdFlush  = 1'b1;
                        idExBubble = 1'b1;
                    end else if (exFpMul || exFpDiv) begin
                        pcWrite     = 1'b0;
                        ifIdWrite   = 1'b0;
                        idExWrite   = 1'b0;
                        exMemBubble = 1'b1;
                        cnt_d       = exFpMul ? MUL_INIT : DIV_INIT;
                        st_d        = FP_BUSY;
                    end else if (int_hit || fp_hit) begin
                        // Freeze fetch/decode one cycle; ID/EX takes a bubble.
                        pcWrite    = 1'b0;
                        ifIdWrite  = 1'b0;
                        idExBubble = 1'b1;
                    end
                end
                FP_BUSY: begin
                    fpBusy = 1'b1;
                    if (cnt_q != '0) begin
                        pcWrite     = 1'b0;
                        ifIdWrite   = 1'b0;
                        idExWrite   = 1'b0;
                        exMemBubble = 1'b1;
                        cnt_d       = cnt_q - CNT_W'(1);
                    end else begin
                        // Release: the held op leaves EX on this edge.
                        st_d = RUN;
                    end
                end
                default: st_d = RUN;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q  <= RUN;
            cnt_q <= '0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (!pcWrite && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stallCycles = stall_q;
`else
    assign stallCycles = 32'd0;
`endif

endmodule
